// File: rtl/soc_it_slave_port_master.sv
// SoC-IT slave-port requester: command FIFO, address/id handshake, then write or read burst.
// Optional ack watchdog enabled by defining SOC_IT_TIMEOUT_EN.
module soc_it_slave_port_master #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned LEN_WIDTH      = 4,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [ID_WIDTH-1:0]     i_cmd_id,
  input  logic [LEN_WIDTH-1:0]    i_cmd_len,
  input  logic [DATA_WIDTH/8-1:0] i_cmd_be,
  input  logic                    i_wr_data_valid,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  output logic                    o_wr_data_ready,
  output logic                    o_rd_data_valid,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic [ID_WIDTH-1:0]     o_rd_data_id,
  output logic                    o_rd_data_last,
  output logic                    o_busy,
  output logic                    o_err_timeout,
  output logic [ADDR_WIDTH-1:0]   o_slave_address,
  output logic [ID_WIDTH-1:0]     o_slave_transaction_id,
  output logic                    o_slave_address_valid,
  input  logic                    i_slave_address_ack,
  output logic [LEN_WIDTH-1:0]    o_slave_wrreq,
  input  logic                    i_slave_wrack,
  output logic [DATA_WIDTH/8-1:0] o_slave_be,
  output logic [DATA_WIDTH-1:0]   o_slave_datain,
  output logic [LEN_WIDTH-1:0]    o_slave_rdreq,
  input  logic                    i_slave_rdack,
  input  logic [DATA_WIDTH-1:0]   i_slave_dataout
);
  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam int unsigned PtrW    = $clog2(CMD_DEPTH);
  localparam int unsigned CmdW    = 1 + ADDR_WIDTH + ID_WIDTH + LEN_WIDTH + BeWidth;
  localparam logic [PtrW:0]      PtrOne = 1;
  localparam logic [LEN_WIDTH-1:0] LenOne = 1;

  typedef enum logic [1:0] {StIdle, StAddr, StWdata, StRdata} state_e;

  state_e                  r_state, w_state_d;
  logic [CmdW-1:0]         r_fifo [CMD_DEPTH];
  logic [PtrW:0]           r_wptr, r_rptr;
  logic                    r_write;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ID_WIDTH-1:0]     r_id;
  logic [BeWidth-1:0]      r_be;
  logic [LEN_WIDTH-1:0]    r_rem, w_rem_d;
  logic                    r_addr_valid, w_addr_valid_d;
  logic                    r_rd_valid, w_rd_valid_d;
  logic                    r_rd_last, w_rd_last_d;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic [ID_WIDTH-1:0]     r_rd_id;
  logic                    r_err, w_tmo_fire;

  logic                    w_full, w_empty, w_push, w_pop;
  logic [LEN_WIDTH-1:0]    w_len_in;
  logic                    w_h_write;
  logic [ADDR_WIDTH-1:0]   w_h_addr;
  logic [ID_WIDTH-1:0]     w_h_id;
  logic [LEN_WIDTH-1:0]    w_h_len;
  logic [BeWidth-1:0]      w_h_be;
  logic                    w_beat_w;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[PtrW] != r_rptr[PtrW]) && (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
  assign w_push   = i_cmd_valid & ~w_full;
  assign w_pop    = (r_state == StIdle) & ~w_empty;
  assign w_len_in = (i_cmd_len == '0) ? LenOne : i_cmd_len;
  assign {w_h_write, w_h_addr, w_h_id, w_h_len, w_h_be} = r_fifo[r_rptr[PtrW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wptr[PtrW-1:0]] <= {i_cmd_write, i_cmd_addr, i_cmd_id, w_len_in, i_cmd_be};
  end

`ifdef SOC_IT_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYCLES+1)-1:0] r_tmo;
  logic                                w_ack_any;
  assign w_ack_any = i_slave_address_ack | i_slave_wrack | i_slave_rdack;

  always_ff @(posedge i_clk) begin
    if (i_rst || r_state == StIdle || w_ack_any || w_state_d != r_state) r_tmo <= '0;
    else                                                               r_tmo <= r_tmo + 1'b1;
  end
`endif

  always_comb begin
    w_state_d      = r_state;
    w_rem_d        = r_rem;
    w_addr_valid_d = r_addr_valid;
    w_rd_valid_d   = 1'b0;
    w_rd_last_d    = 1'b0;
    w_beat_w       = 1'b0;
    w_tmo_fire     = 1'b0;
    o_slave_wrreq  = '0;
    o_slave_rdreq  = '0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_state_d      = StAddr;
          w_rem_d        = w_h_len;
          w_addr_valid_d = 1'b1;
        end
      end
      StAddr: begin
        if (i_slave_address_ack) begin
          w_addr_valid_d = 1'b0;
          w_state_d      = r_write ? StWdata : StRdata;
        end
      end
      StWdata: begin
        o_slave_wrreq = i_wr_data_valid ? r_rem : '0;
        w_beat_w      = i_wr_data_valid & i_slave_wrack;
        if (w_beat_w) begin
          w_rem_d = r_rem - LenOne;
          if (r_rem == LenOne) w_state_d = StIdle;
        end
      end
      StRdata: begin
        o_slave_rdreq = r_rem;
        if (i_slave_rdack) begin
          w_rem_d      = r_rem - LenOne;
          w_rd_valid_d = 1'b1;
          w_rd_last_d  = (r_rem == LenOne);
          if (r_rem == LenOne) w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
`ifdef SOC_IT_TIMEOUT_EN
    // Drop the stalled command; nothing is acked this cycle so no beat is lost.
    if (r_state != StIdle && !w_ack_any && r_tmo == TIMEOUT_CYCLES - 1) begin
      w_state_d      = StIdle;
      w_rem_d        = '0;
      w_addr_valid_d = 1'b0;
      w_tmo_fire     = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_id         <= '0;
      r_be         <= '0;
      r_rem        <= '0;
      r_addr_valid <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_rd_data    <= '0;
      r_rd_id      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_rem        <= w_rem_d;
      r_addr_valid <= w_addr_valid_d;
      r_rd_valid   <= w_rd_valid_d;
      r_rd_last    <= w_rd_last_d;
      r_err        <= w_tmo_fire;
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop) begin
        r_rptr  <= r_rptr + PtrOne;
        r_write <= w_h_write;
        r_addr  <= w_h_addr;
        r_id    <= w_h_id;
        r_be    <= w_h_be;
      end
      if (w_rd_valid_d) begin
        r_rd_data <= i_slave_dataout;
        r_rd_id   <= r_id;
      end
    end
  end

  assign o_cmd_ready            = ~w_full;
  assign o_wr_data_ready        = w_beat_w;
  assign o_rd_data_valid        = r_rd_valid;
  assign o_rd_data              = r_rd_data;
  assign o_rd_data_id           = r_rd_id;
  assign o_rd_data_last         = r_rd_last;
  assign o_busy                 = (r_state != StIdle) | ~w_empty;
  assign o_err_timeout          = r_err;
  assign o_slave_address        = r_addr;
  assign o_slave_transaction_id = r_id;
  assign o_slave_address_valid  = r_addr_valid;
  assign o_slave_be             = r_be;
  assign o_slave_datain         = i_wr_data;
endmodule
